down_counter: RTL and testbench

Loadable down-counter/timer: the count-down counterpart to the team's free-running up counter. Accepts a start value over a valid/ready load handshake and counts down to zero on enabled cycles. It signals terminal count, then stops (one-shot) or reloads (auto-reload). Used for timeouts, pacing and periodic ticks in datapath control.

---
 rtl/down_counter_pkg.sv | 15 +
 rtl/down_counter.sv | 131 +++++++++++++
 tb/tb_down_counter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/down_counter_pkg.sv
// Shared counter definitions: FSM state encoding used by both the
// up- and down-counter blocks so they agree on one set of codes.
package down_counter_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_DONE = DONE
    } cnt_state_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter / timer with one-shot or auto-reload mode.
// Ports:
//   clk_i         clock, all state on rising edge
//   a_rst_n_i     asynchronous active-low reset
//   en_i          count enable (low = hold)
//   stop_i        abort run, return to IDLE
//   load_valid_i  load request
//   load_ready_o  load accepted when high (state != RUN)
//   load_val_i    start/reload value, clamped to MAX_VALUE
//   auto_reload_i mode sampled on accept: 1 periodic, 0 one-shot
//   val_o         current count
//   busy_o        high in RUN
//   tc_o          terminal-count pulse, one clock wide
//   done_o        high in DONE
module down_counter
    import down_counter_pkg::*;
#(
    parameter int MAX_VALUE = 255,
    parameter int WIDTH     = $clog2(MAX_VALUE + 1)
) (
    input  logic             clk_i,
    input  logic             a_rst_n_i,
    input  logic             en_i,
    input  logic             stop_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] val_o,
    output logic             busy_o,
    output logic             tc_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    cnt_state_e       state;
    cnt_state_e       state_n;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_n;
    logic             mode;
    logic             mode_n;
    logic             tc;
    logic             tc_n;

    logic             accept;
    logic [WIDTH-1:0] load_clamp;

    // Ready depends only on the state register.
    assign load_ready_o = (state != ST_RUN);
    assign accept       = load_valid_i & load_ready_o;

    // ">=" keeps the compare non-constant when WIDTH exactly fits MAX_VALUE.
    assign load_clamp = (load_val_i >= MAXV) ? MAXV : load_val_i;

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state  <= ST_IDLE;
            count  <= '0;
            reload <= '0;
            mode   <= 1'b0;
            tc     <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            reload <= reload_n;
            mode   <= mode_n;
            tc     <= tc_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        mode_n   = mode;
        tc_n     = 1'b0;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    count_n  = load_clamp;
                    reload_n = load_clamp;
                    mode_n   = auto_reload_i;
                    if (load_clamp == '0) begin
                        // Zero load expires at once in either mode.
                        state_n = ST_DONE;
                        tc_n    = 1'b1;
                    end else begin
                        state_n = ST_RUN;
                    end
                end else if (stop_i && state == ST_DONE) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_n = ST_IDLE;
                    count_n = '0;
                end else if (en_i) begin
                    if (count > ONE) begin
                        count_n = count - ONE;
                    end else if (count == ONE) begin
                        count_n = '0;
                        tc_n    = 1'b1;
                        if (!mode) begin
                            state_n = ST_DONE;
                        end
                    end else begin
                        // count == 0 in RUN only follows a periodic tc.
                        count_n = reload;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                count_n = '0;
            end
        endcase
    end

    assign val_o  = count;
    assign tc_o   = tc;
    assign busy_o = (state == ST_RUN);
    assign done_o = (state == ST_DONE);

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (MAX_VALUE 255, 9-bit
// port so over-range loads can be presented and clamped).
module tb_down_counter;

    localparam int MAXV = 255;
    localparam int W    = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         stop = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_val = '0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] val;
    logic         busy;
    logic         tc;
    logic         done;

    int passed = 0;
    int total  = 0;

    down_counter #(.MAX_VALUE(MAXV), .WIDTH(W)) dut (
        .clk_i         (clk),
        .a_rst_n_i     (rst_n),
        .en_i          (en),
        .stop_i        (stop),
        .load_valid_i  (load_valid),
        .load_ready_o  (load_ready),
        .load_val_i    (load_val),
        .auto_reload_i (auto_reload),
        .val_o         (val),
        .busy_o        (busy),
        .tc_o          (tc),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // val, tc, busy, done, ready in one call
    task automatic chk_all(input string tag, input int v, input int t,
                           input int b, input int d, input int r);
        chk({tag, ".val"}, int'(val), v);
        chk({tag, ".tc"}, int'(tc), t);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".done"}, int'(done), d);
        chk({tag, ".ready"}, int'(load_ready), r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v, input logic ar);
        load_valid  = 1'b1;
        load_val    = W'(v);
        auto_reload = ar;
        tick();
        load_valid  = 1'b0;
    endtask

    initial begin
        int exp_v[8];
        int pat_en[6];
        int pat_v[6];

        // Reset state
        #2;
        chk_all("rst", 0, 0, 0, 0, 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("post_rst", 0, 0, 0, 0, 1);

        // 1: reset mid-run at count 5
        en = 1'b1;
        load(7, 1'b0);
        tick();
        tick();
        chk("t1.count5", int'(val), 5);
        rst_n = 1'b0;
        #1;
        chk_all("t1.async", 0, 0, 0, 0, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // 2: one-shot load 3
        load(3, 1'b0);
        chk_all("t2.v3", 3, 0, 1, 0, 0);
        tick();
        chk_all("t2.v2", 2, 0, 1, 0, 0);
        tick();
        chk_all("t2.v1", 1, 0, 1, 0, 0);
        tick();
        chk_all("t2.v0", 0, 1, 0, 1, 1);
        tick();
        chk_all("t2.hold", 0, 0, 0, 1, 1);

        // 3: auto-reload load 2 from DONE
        load(2, 1'b1);
        chk_all("t3.c0", 2, 0, 1, 0, 0);
        exp_v = '{1, 0, 2, 1, 0, 2, 1, 0};
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t3.c%0d.val", i + 1), int'(val), exp_v[i]);
            chk($sformatf("t3.c%0d.tc", i + 1), int'(tc),
                (exp_v[i] == 0) ? 1 : 0);
            chk($sformatf("t3.c%0d.done", i + 1), int'(done), 0);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("t3.stop", 0, 0, 0, 0, 1);

        // 4: one-shot load 4 with enable gaps; load during RUN ignored
        en = 1'b0;
        load(4, 1'b0);
        chk_all("t4.v4", 4, 0, 1, 0, 0);
        pat_en = '{1, 0, 0, 1, 1, 1};
        pat_v  = '{3, 3, 3, 2, 1, 0};
        for (int i = 0; i < 6; i++) begin
            en = pat_en[i][0];
            load_valid = (i == 1 || i == 2);
            load_val = W'(9);
            tick();
            chk($sformatf("t4.s%0d.val", i), int'(val), pat_v[i]);
            chk($sformatf("t4.s%0d.tc", i), int'(tc), (i == 5) ? 1 : 0);
            if (i < 5)
                chk($sformatf("t4.s%0d.ready", i), int'(load_ready), 0);
        end
        load_valid = 1'b0;
        tick();
        chk_all("t4.after", 0, 0, 0, 1, 1);

        // 5: clamp and zero load
        en = 1'b1;
        load(300, 1'b0);
        chk_all("t5.clamp", 255, 0, 1, 0, 0);
        tick();
        chk("t5.dec", int'(val), 254);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        load(0, 1'b1);
        chk_all("t5.zero", 0, 1, 0, 1, 1);
        tick();
        chk_all("t5.zero2", 0, 0, 0, 1, 1);

        // 6: stop at 7; load beats stop in DONE; stop alone in DONE
        load(10, 1'b0);
        tick();
        tick();
        tick();
        chk("t6.at7", int'(val), 7);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("t6.stop", 0, 0, 0, 0, 1);
        load(0, 1'b0);
        tick();
        chk("t6.indone", int'(done), 1);
        en = 1'b0;
        stop = 1'b1;
        load(5, 1'b0);
        stop = 1'b0;
        chk_all("t6.loadwins", 5, 0, 1, 0, 0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_all("t6.done", 0, 1, 0, 1, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("t6.stopdone", 0, 0, 0, 0, 1);
        // stop in IDLE has no effect
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("t6.stopidle", 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
